// File: rtl/serial_paralelo_rx_if.sv
// Serial receive bus between the serial bit source and serial_paralelo_rx.
//   data_in     : serial bit, MSB first, one per clk_32f
//   data_out    : recovered byte
//   valid_out   : 1 = data_out is payload, 0 = idle/COM or nothing yet
//   byte_strobe : one-cycle pulse when data_out/valid_out update
//   active      : link aligned, sticky until reset
// master drives the serial bit and observes the byte side; slave is the receiver.
interface serial_paralelo_rx_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       byte_strobe;
  logic       active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  byte_strobe,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output byte_strobe,
    output active
  );
endinterface

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver for the phy_tx bitstream.
// Finds the byte boundary by matching COM on a sliding 8-bit window, confirms it with
// BC_COUNT consecutive aligned COM bytes, then emits one byte every 8 clocks.
// Ports:
//   clk_32f : bit clock, all logic on the rising edge
//   reset   : synchronous, active-high
//   bus     : serial_paralelo_rx_if.slave (data_in in; data_out, valid_out,
//             byte_strobe, active out)
module serial_paralelo_rx #(
  parameter logic [7:0]  COM      = 8'hBC,
  parameter int unsigned BC_COUNT = 4
) (
  input logic                  clk_32f,
  input logic                  reset,
  serial_paralelo_rx_if.slave  bus
);

  localparam int unsigned BcW = $clog2(BC_COUNT + 1);

  typedef enum logic [1:0] {
    StSearch,
    StAlign,
    StActive
  } state_e;

  state_e         state_q, state_d;
  logic [7:0]     sr_q, sr_d;
  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [BcW-1:0] bc_cnt_q, bc_cnt_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic           strobe_q, strobe_d;
  logic           active_q, active_d;

  logic           sr_is_com;
  logic           boundary;
  logic [BcW-1:0] bc_next;

  // All decisions look at the registered window, i.e. the 8 bits sampled before this edge.
  assign sr_is_com = (sr_q == COM);
  assign boundary  = (bit_cnt_q == 3'd0);
  assign bc_next   = bc_cnt_q + 1'b1;

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q   <= StSearch;
      sr_q      <= 8'h00;
      bit_cnt_q <= 3'd0;
      bc_cnt_q  <= '0;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      strobe_q  <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      strobe_q  <= strobe_d;
      active_q  <= active_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sr_d      = {sr_q[6:0], bus.data_in};
    bit_cnt_d = bit_cnt_q + 3'd1;
    bc_cnt_d  = bc_cnt_q;
    data_d    = data_q;
    valid_d   = valid_q;
    strobe_d  = 1'b0;
    active_d  = active_q;

    unique case (state_q)
      StSearch: begin
        bit_cnt_d = 3'd0;
        if (sr_is_com) begin
          // Starting at 1 puts the next boundary exactly 8 edges after this match.
          bit_cnt_d = 3'd1;
          bc_cnt_d  = BcW'(1);
          if (BC_COUNT <= 1) begin
            state_d  = StActive;
            active_d = 1'b1;
          end else begin
            state_d = StAlign;
          end
        end
      end

      StAlign: begin
        if (boundary) begin
          if (sr_is_com) begin
            bc_cnt_d = bc_next;
            if (bc_next == BcW'(BC_COUNT)) begin
              state_d  = StActive;
              active_d = 1'b1;
            end
          end else begin
            // Lost alignment: bits already in sr are not rescanned, search restarts next edge.
            bc_cnt_d  = '0;
            bit_cnt_d = 3'd0;
            state_d   = StSearch;
          end
        end
      end

      StActive: begin
        // No loss-of-lock detection; only reset leaves this state.
        if (boundary) begin
          data_d   = sr_q;
          valid_d  = !sr_is_com;
          strobe_d = 1'b1;
        end
      end

      default: begin
        state_d   = StSearch;
        bit_cnt_d = 3'd0;
        bc_cnt_d  = '0;
      end
    endcase
  end

  assign bus.data_out    = data_q;
  assign bus.valid_out   = valid_q;
  assign bus.byte_strobe = strobe_q;
  assign bus.active      = active_q;

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Self-checking bench for serial_paralelo_rx. Each segment of serial bits (between resets)
// is turned into expected per-edge outputs by a stream-level model: find the first COM
// window, require COM every 8 bits after it, then emit every following 8-bit window.
module tb_serial_paralelo_rx;

  localparam logic [7:0]  Com     = 8'hBC;
  localparam int unsigned BcCount = 4;

  logic clk_32f = 1'b0;
  logic reset   = 1'b1;

  serial_paralelo_rx_if bus ();

  serial_paralelo_rx #(
    .COM      (Com),
    .BC_COUNT (BcCount)
  ) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk_32f = ~clk_32f;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Current segment bits and the model's per-edge expectations.
  logic       seg[$];
  bit         m_act[];
  bit         m_stb[];
  logic [7:0] m_dat[];
  bit         m_val[];

  // Window seen by the receiver at segment edge k: bits k-8..k-1, zeros before the segment.
  function automatic logic [7:0] win(input int k);
    logic [7:0] w = 8'h00;
    for (int i = 0; i < 8; i++) begin
      int idx = k - 8 + i;
      w = {w[6:0], (idx >= 0) ? seg[idx] : 1'b0};
    end
    return w;
  endfunction

  task automatic build_model();
    int  n        = seg.size();
    int  k        = 0;
    int  act_edge = -1;
    bit  done     = 0;
    logic [7:0] cur_d = 8'h00;
    bit  cur_v = 0;
    m_act = new[n];
    m_stb = new[n];
    m_dat = new[n];
    m_val = new[n];
    for (int i = 0; i < n; i++) m_stb[i] = 0;
    while (k < n && !done) begin
      if (win(k) == Com) begin
        int m = k;
        bit fail = 0;
        for (int j = 1; j < int'(BcCount); j++) begin
          int e = m + 8 * j;
          if (e >= n) begin
            done = 1;
            break;
          end
          if (win(e) != Com) begin
            fail = 1;
            k = e + 1;
            break;
          end
        end
        if (!done && !fail) begin
          act_edge = m + 8 * (int'(BcCount) - 1);
          for (int e = act_edge + 8; e < n; e += 8) m_stb[e] = 1;
          done = 1;
        end
      end else begin
        k++;
      end
    end
    for (int i = 0; i < n; i++) begin
      if (m_stb[i]) begin
        cur_d = win(i);
        cur_v = (cur_d != Com);
      end
      m_dat[i] = cur_d;
      m_val[i] = cur_v;
      m_act[i] = (act_edge >= 0) && (i >= act_edge);
    end
  endtask

  // Expected values for the outputs after the most recent edge.
  bit         chk_en = 0;
  logic [7:0] e_dat  = 8'h00;
  logic       e_val  = 1'b0;
  logic       e_stb  = 1'b0;
  logic       e_act  = 1'b0;

  always @(negedge clk_32f) begin
    if (chk_en) begin
      check("data_out",    {24'd0, bus.data_out},    {24'd0, e_dat});
      check("valid_out",   {31'd0, bus.valid_out},   {31'd0, e_val});
      check("byte_strobe", {31'd0, bus.byte_strobe}, {31'd0, e_stb});
      check("active",      {31'd0, bus.active},      {31'd0, e_act});
    end
  end

  // Capture of strobed bytes for the long-run scoreboard.
  int         cyc    = 0;
  bit         cap_en = 0;
  logic [8:0] cap[$];
  int         cap_t[$];

  always @(posedge clk_32f) cyc <= cyc + 1;

  always @(negedge clk_32f) begin
    if (cap_en && bus.byte_strobe) begin
      cap.push_back({bus.valid_out, bus.data_out});
      cap_t.push_back(cyc);
    end
  end

  task automatic do_reset(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      reset       = 1'b1;
      bus.data_in = 1'($urandom_range(0, 1));
      @(posedge clk_32f);
      #1;
      e_dat  = 8'h00;
      e_val  = 1'b0;
      e_stb  = 1'b0;
      e_act  = 1'b0;
      chk_en = 1;
    end
    reset = 1'b0;
  endtask

  task automatic run_seg();
    build_model();
    for (int k = 0; k < seg.size(); k++) begin
      bus.data_in = seg[k];
      @(posedge clk_32f);
      #1;
      e_dat  = m_dat[k];
      e_val  = m_val[k];
      e_stb  = m_stb[k];
      e_act  = m_act[k];
      chk_en = 1;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) seg.push_back(b[i]);
  endtask

  task automatic push_bits(input int cnt, input logic [7:0] v);
    for (int i = cnt - 1; i >= 0; i--) seg.push_back(v[i]);
  endtask

  task automatic push_com(input int cnt);
    for (int i = 0; i < cnt; i++) push_byte(Com);
  endtask

  logic [7:0] rnd[$];

  initial begin
    bus.data_in = 1'b0;

    // 1: clean start
    do_reset(4);
    seg.delete();
    push_com(4); push_byte(8'h55); push_byte(8'hA3); push_byte(Com); push_bits(4, 8'h0);
    build_model();
    check("pin1_act_before", {31'd0, m_act[31]}, 32'd0);
    check("pin1_act_rise",   {31'd0, m_act[32]}, 32'd1);
    check("pin1_stb40",      {31'd0, m_stb[40]}, 32'd1);
    check("pin1_dat40",      {24'd0, m_dat[40]}, 32'h55);
    check("pin1_dat48",      {24'd0, m_dat[48]}, 32'hA3);
    check("pin1_dat56",      {24'd0, m_dat[56]}, 32'hBC);
    check("pin1_val56",      {31'd0, m_val[56]}, 32'd0);
    check("pin1_stb44",      {31'd0, m_stb[44]}, 32'd0);
    run_seg();

    // 2: misaligned start, 3 junk bits
    do_reset(2);
    seg.delete();
    push_bits(3, 8'h05);
    push_com(4); push_byte(8'h55); push_byte(8'hA3); push_byte(Com); push_bits(4, 8'h0);
    build_model();
    check("pin2_act_before", {31'd0, m_act[34]}, 32'd0);
    check("pin2_act_rise",   {31'd0, m_act[35]}, 32'd1);
    check("pin2_dat43",      {24'd0, m_dat[43]}, 32'h55);
    run_seg();

    // 3: broken preamble then re-lock
    do_reset(2);
    seg.delete();
    push_com(3); push_byte(8'h12); push_com(4); push_byte(8'h77); push_bits(4, 8'h0);
    build_model();
    check("pin3_no_act32",  {31'd0, m_act[32]}, 32'd0);
    check("pin3_no_act63",  {31'd0, m_act[63]}, 32'd0);
    check("pin3_act64",     {31'd0, m_act[64]}, 32'd1);
    check("pin3_stb72",     {31'd0, m_stb[72]}, 32'd1);
    check("pin3_dat72",     {24'd0, m_dat[72]}, 32'h77);
    run_seg();

    // 4: false comma straddling 0x0B,0xC0
    do_reset(2);
    seg.delete();
    push_byte(8'h0B); push_byte(8'hC0); push_com(4); push_byte(8'h3C); push_bits(4, 8'h0);
    build_model();
    check("pin4_false_win", {24'd0, win(12)},    32'hBC);
    check("pin4_no_act47",  {31'd0, m_act[47]}, 32'd0);
    check("pin4_act48",     {31'd0, m_act[48]}, 32'd1);
    check("pin4_dat56",     {24'd0, m_dat[56]}, 32'h3C);
    check("pin4_val56",     {31'd0, m_val[56]}, 32'd1);
    run_seg();

    // 5: reset mid-byte while active, then re-lock
    do_reset(2);
    seg.delete();
    push_com(4); push_byte(8'h12); push_bits(3, 8'h05);
    build_model();
    check("pin5_dat40", {24'd0, m_dat[40]}, 32'h12);
    run_seg();
    do_reset(1);
    seg.delete();
    push_com(4); push_byte(8'hF0); push_bits(4, 8'h0);
    build_model();
    check("pin5_dat40b", {24'd0, m_dat[40]}, 32'hF0);
    check("pin5_val40b", {31'd0, m_val[40]}, 32'd1);
    run_seg();

    // 6: long run of random non-COM bytes after a random-length junk prefix
    do_reset(2);
    seg.delete();
    rnd.delete();
    push_bits(int'($urandom_range(0, 7)), 8'($urandom));
    push_com(4);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      do b = 8'($urandom); while (b == Com);
      rnd.push_back(b);
      push_byte(b);
    end
    push_bits(4, 8'h0);
    cap.delete();
    cap_t.delete();
    cap_en = 1;
    run_seg();
    cap_en = 0;
    check("long_count", cap.size(), 32'd256);
    for (int i = 0; i < 256 && i < cap.size(); i++) begin
      check("long_byte", {23'd0, cap[i]}, {23'd0, 1'b1, rnd[i]});
      if (i > 0) check("long_period", cap_t[i] - cap_t[i-1], 32'd8);
    end

    // 7: random bit soup with an embedded preamble and arbitrary payload
    for (int r = 0; r < 3; r++) begin
      do_reset(1 + int'($urandom_range(0, 2)));
      seg.delete();
      for (int i = 0; i < int'($urandom_range(40, 80)); i++) seg.push_back(1'($urandom));
      push_com(4);
      for (int i = 0; i < 8; i++) push_byte(($urandom_range(0, 3) == 0) ? Com : 8'($urandom));
      push_bits(5, 8'h0);
      run_seg();
    end

    chk_en = 0;
    @(posedge clk_32f);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_paralelo_rx.md
Name: serial_paralelo_rx

Overview:
Receive-side serial-to-parallel converter that directly consumes the serial bitstream produced by phy_tx. Runs on clk_32f and finds the byte boundary by matching the COM character (0xBC) on a sliding window. It declares the link active after BC_COUNT consecutive aligned COM bytes. It then emits one parallel byte per 8 clocks, flagging COM idle bytes as invalid, for the downstream lane demux.

Parameters:
COM, 8'hBC, comma/idle character used for alignment and idle fill
BC_COUNT, 4, consecutive aligned COM bytes (including the first match) required to assert active

Ports:
clk_32f  input  1  bit clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
data_in  input  1  serial bit from phy_tx, MSB first, one bit per clk_32f
data_out  output  8  recovered byte, registered
valid_out  output  1  1 = data_out is payload; 0 = idle/COM or no data
byte_strobe  output  1  one-cycle pulse when data_out/valid_out are updated
active  output  1  link aligned and delivering bytes; sticky until reset

Behaviour:
- Reset (reset=1 at an edge): sr=0, bit_cnt=0, bc_cnt=0, state=SEARCH. Outputs: data_out=8'h00, valid_out=0, byte_strobe=0, active=0. Reset asserted mid-operation clears everything at that edge, with no partial byte output.
- Shift register: sr <= {sr[6:0], data_in} every non-reset edge, in all states. All comparisons below use the registered sr value.
- bit_cnt: 3-bit counter that wraps 7->0. The boundary condition is bit_cnt==0 in ALIGN or ACTIVE.
- SEARCH:
  - Compare sr against COM on every edge.
  - On a match: bit_cnt<=1, bc_cnt<=1, go to ALIGN. The next boundary is exactly 8 edges later.
  - No match: stay in SEARCH; bit_cnt holds 0.
- ALIGN: bit_cnt increments every edge. At a boundary:
  - If sr==COM: bc_cnt<=bc_cnt+1. If bc_cnt+1==BC_COUNT, go to ACTIVE and set active<=1 on that edge.
  - If sr!=COM: bc_cnt<=0, bit_cnt<=0, go to SEARCH. The bits already in sr are not rescanned specially; search resumes on the next edge.
  - No byte_strobe is issued in ALIGN.
- ACTIVE: bit_cnt increments every edge. At each boundary:
  - data_out<=sr, valid_out<=(sr!=COM), byte_strobe<=1.
  - At all other edges byte_strobe<=0; data_out and valid_out hold.
  - No loss-of-lock detection: ACTIVE exits only on reset.
- Latency: the last bit of a byte is sampled into sr at edge N. data_out, valid_out and byte_strobe appear after edge N+1.
- First strobe: the byte after the BC_COUNT-th COM byte. Its strobe follows the active rising edge by exactly 8 cycles.
- Steady state: byte_strobe period is exactly 8 clocks and is never back-to-back.
- A false COM match straddling two real bytes in SEARCH fails at the next boundary and returns to SEARCH. active must not assert on it.
- data_in X/Z handling is out of scope; the bench must drive 0/1 only.

Test Plan:
1. Clean start: reset 4 cycles, send BC,BC,BC,BC,0x55,0xA3,BC MSB-first.
   - active rises on the edge evaluating the 4th BC.
   - Strobes then deliver 0x55/v=1, 0xA3/v=1, 0xBC/v=0, spaced 8 clocks.
2. Misaligned start: 3 junk bits (1,0,1), then the same stream as scenario 1 -> identical outputs, shifted 3 clocks later.
3. Broken preamble: BC,BC,BC,0x12, then BC x4, then 0x77.
   - active stays 0 through 0x12 and returns to SEARCH.
   - Re-locks on the next 4 BCs; first strobe is 0x77/v=1.
4. False comma: the stream 0x0B,0xC0 contains 0xBC across the boundary, followed by BC x4 and 0x3C.
   - The false match fails and active does not assert early.
   - After the 4 aligned BCs, 0x3C is output with v=1.
5. Reset mid-operation: in ACTIVE, assert reset for 1 cycle mid-byte.
   - All outputs return to 0 at the next edge.
   - A fresh BC x4 + 0xF0 sequence re-activates and delivers 0xF0/v=1.
6. Long run: 256 random non-COM bytes after lock -> every byte received in order with v=1, one strobe per 8 clocks, active held at 1 throughout.
